jmp_stack: RTL and testbench
============================

JMP_STACK -- requirements
Module: jmp_stack

Interface
REQ-001 Parameter WIDTH, default 8: address/data width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries, DEPTH >= 2. SPW = clog2(DEPTH+1).
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 jmp_en  input  1  qualifies jmp_mode; low = sequential fetch.
REQ-006 jmp_mode  input  3  000 ABS, 001 BASE, 010 REL, 011 LR, 100 CALL, 101 RET, 110/111 reserved.
REQ-007 pc_in  input  WIDTH  address of the current instruction.
REQ-008 base_reg_offset  input  WIDTH  offset/immediate operand.
REQ-009 base_reg_ld  input  1  load the base register.
REQ-010 base_reg_data  input  WIDTH  base register load value.
REQ-011 lr_addr  input  WIDTH  external link address.
REQ-012 err_clr  input  1  clears the sticky error flags.
REQ-013 out_addr  output  WIDTH  next fetch address; combinational.
REQ-014 jmp_taken  output  1  out_addr is not pc_in+1 because of a jump; combinational.
REQ-015 sp  output  SPW  number of valid stack entries; registered.
REQ-016 stack_full  output  1  sp == DEPTH.
REQ-017 stack_empty  output  1  sp == 0.
REQ-018 ovf_err  output  1  sticky push-on-full flag; registered.
REQ-019 unf_err  output  1  sticky pop-on-empty flag; registered.

Function
REQ-020 All sums SHALL be modulo 2^WIDTH. seq = pc_in+1. base = current base-register value.
REQ-021 If jmp_en is 0, or jmp_mode is reserved: out_addr = seq, jmp_taken = 0, stack unchanged.
REQ-022 ABS SHALL output base_reg_offset.
REQ-023 BASE SHALL output base + base_reg_offset.
REQ-024 REL SHALL output pc_in + base_reg_offset, with the offset taken as two's complement.
REQ-025 LR SHALL output lr_addr.
REQ-026 CALL:
- out_addr = base + base_reg_offset.
- At the next clk edge, seq is pushed and sp increments.
REQ-027 CALL with stack full:
- The jump is still taken.
- The push is dropped, sp is unchanged, and ovf_err is set at the edge.
REQ-028 RET with stack non-empty: out_addr = top entry; at the next edge the entry is popped and sp decrements.
REQ-029 RET with stack empty: out_addr = seq, jmp_taken = 0, and unf_err is set at the edge.
REQ-030 jmp_taken SHALL be 1 for every valid enabled mode except RET-on-empty, even if the target equals seq.
REQ-031 The base register SHALL load base_reg_data at the edge when base_reg_ld = 1.
REQ-032 A same-cycle base_reg_ld with BASE or CALL SHALL use the old base value for the target.
REQ-033 Stack is LIFO:
- At most one push or pop per cycle.
- Entries not at the top are never modified.
- sp is never below 0 or above DEPTH.
REQ-034 err_clr SHALL clear both flags at the edge.
REQ-035 If err_clr coincides with a new error, the new error SHALL win (flag set).
REQ-036 Outputs SHALL have no combinational path from base_reg_ld or base_reg_data.

Reset
REQ-037 Asserting rst SHALL immediately, without waiting for a clock edge, set:
- base register = 0, sp = 0, all stack entries = 0;
- ovf_err = 0, unf_err = 0;
- hence stack_empty = 1, stack_full = 0.
REQ-038 rst asserted mid-CALL or mid-RET SHALL discard the pending push/pop.
REQ-039 The first edge after rst deassertion SHALL operate normally.

Verification
REQ-040 Base/relative (WIDTH=8, DEPTH=4):
- Load base 0x0A, then BASE with offset 0xA7 -> out_addr 0xB1.
- REL with pc_in 0x10, offset 0xFE -> out_addr 0x0E.
- ABS with offset 0x12 -> out_addr 0x12.
REQ-041 Nested calls:
- CALL at pc 0x20, then 0x40, then 0x60 -> sp 1, 2, 3.
- Three RETs -> out_addr 0x61, 0x41, 0x21.
- Final state: sp 0, stack_empty 1.
REQ-042 Overflow:
- 4 CALLs -> stack_full 1.
- 5th CALL -> jmp_taken 1, sp stays 4, ovf_err 1.
- Top entry still holds the 4th return address.
- err_clr -> ovf_err 0.
REQ-043 Underflow: RET on empty with pc_in 0x33 -> out_addr 0x34, jmp_taken 0, unf_err 1 after the edge.
REQ-044 Simultaneous events:
- base_reg_ld 0x50 with CALL offset 0x01 while old base is 0x0A -> out_addr 0x0B.
- Next-cycle BASE with offset 0x01 -> out_addr 0x51.
- LR with lr_addr 0x69 -> out_addr 0x69.
REQ-045 Reset mid-operation:
- sp = 2, then rst pulsed between edges -> sp 0, errors 0 immediately.
- Following RET -> unf_err 1.

Source files
------------

// File: rtl/jmp_stack.sv
// Next-fetch address generator: absolute/base/relative/link jumps plus a
// bounded call/return stack with sticky overflow/underflow flags.
module jmp_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned SPW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jmp_en,
  input  logic [2:0]       jmp_mode,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] base_reg_offset,
  input  logic             base_reg_ld,
  input  logic [WIDTH-1:0] base_reg_data,
  input  logic [WIDTH-1:0] lr_addr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_addr,
  output logic             jmp_taken,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] M_ABS  = 3'b000;
  localparam logic [2:0] M_BASE = 3'b001;
  localparam logic [2:0] M_REL  = 3'b010;
  localparam logic [2:0] M_LR   = 3'b011;
  localparam logic [2:0] M_CALL = 3'b100;
  localparam logic [2:0] M_RET  = 3'b101;

  logic [WIDTH-1:0] base_q, base_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] top;
  logic             push, pop, ovf_set, unf_set;

  assign seq = pc_in + WIDTH'(1);
  assign top = stack_q[AW'(sp_q - SPW'(1))];

  // Target selection and stack/error requests; targets see only the current base.
  always_comb begin
    out_addr  = seq;
    jmp_taken = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (jmp_en) begin
      case (jmp_mode)
        M_ABS: begin
          out_addr  = base_reg_offset;
          jmp_taken = 1'b1;
        end
        M_BASE: begin
          out_addr  = base_q + base_reg_offset;
          jmp_taken = 1'b1;
        end
        M_REL: begin
          out_addr  = pc_in + base_reg_offset;
          jmp_taken = 1'b1;
        end
        M_LR: begin
          out_addr  = lr_addr;
          jmp_taken = 1'b1;
        end
        M_CALL: begin
          out_addr  = base_q + base_reg_offset;
          jmp_taken = 1'b1;
          if (full_q) ovf_set = 1'b1;
          else        push    = 1'b1;
        end
        M_RET: begin
          if (empty_q) begin
            unf_set = 1'b1;
          end else begin
            out_addr  = top;
            jmp_taken = 1'b1;
            pop       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state: base register, stack contents/pointer, sticky flags.
  always_comb begin
    base_d  = base_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    if (base_reg_ld) base_d = base_reg_data;
    if (push) begin
      stack_d[AW'(sp_q)] = seq;
      sp_d               = sp_q + SPW'(1);
    end else if (pop) begin
      sp_d = sp_q - SPW'(1);
    end
    ovf_d   = ovf_set | (ovf_q & ~err_clr);
    unf_d   = unf_set | (unf_q & ~err_clr);
    full_d  = (sp_d == SPW'(DEPTH));
    empty_d = (sp_d == SPW'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      sp_q    <= '0;
      stack_q <= '{default: '0};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      base_q  <= base_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign sp          = sp_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_jmp_stack.sv
// Directed bench for jmp_stack with a queue-based reference model checked
// every negative edge, plus literal expectations for the key scenarios.
module tb_jmp_stack;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             jmp_en;
  logic [2:0]       jmp_mode;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] base_reg_offset;
  logic             base_reg_ld;
  logic [WIDTH-1:0] base_reg_data;
  logic [WIDTH-1:0] lr_addr;
  logic             err_clr;
  logic [WIDTH-1:0] out_addr;
  logic             jmp_taken;
  logic [SPW-1:0]   sp;
  logic             stack_full;
  logic             stack_empty;
  logic             ovf_err;
  logic             unf_err;

  int checks   = 0;
  int failures = 0;

  jmp_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jmp_en(jmp_en), .jmp_mode(jmp_mode),
    .pc_in(pc_in), .base_reg_offset(base_reg_offset),
    .base_reg_ld(base_reg_ld), .base_reg_data(base_reg_data),
    .lr_addr(lr_addr), .err_clr(err_clr), .out_addr(out_addr),
    .jmp_taken(jmp_taken), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue for the stack, plain variables for the rest.
  logic [WIDTH-1:0] m_stk[$];
  logic [WIDTH-1:0] m_base;
  bit               m_ovf, m_unf;

  function automatic void model_comb(output logic [WIDTH-1:0] o, output bit t,
                                     output bit psh, output bit pp,
                                     output bit oe, output bit ue);
    logic [WIDTH-1:0] s;
    s = pc_in + 8'd1;
    o = s; t = 0; psh = 0; pp = 0; oe = 0; ue = 0;
    if (jmp_en) begin
      if (jmp_mode == 3'd0) begin o = base_reg_offset; t = 1; end
      else if (jmp_mode == 3'd1) begin o = m_base + base_reg_offset; t = 1; end
      else if (jmp_mode == 3'd2) begin
        o = WIDTH'(int'(pc_in) + int'($signed(base_reg_offset))); t = 1;
      end
      else if (jmp_mode == 3'd3) begin o = lr_addr; t = 1; end
      else if (jmp_mode == 3'd4) begin
        o = m_base + base_reg_offset; t = 1;
        if (m_stk.size() == DEPTH) oe = 1; else psh = 1;
      end
      else if (jmp_mode == 3'd5) begin
        if (m_stk.size() == 0) ue = 1;
        else begin o = m_stk[m_stk.size()-1]; t = 1; pp = 1; end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [WIDTH-1:0] o;
    bit t, psh, pp, oe, ue;
    if (rst) begin
      m_stk.delete();
      m_base = '0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      model_comb(o, t, psh, pp, oe, ue);
      if (psh) m_stk.push_back(pc_in + 8'd1);
      if (pp)  void'(m_stk.pop_back());
      m_ovf = oe | (m_ovf & !err_clr);
      m_unf = ue | (m_unf & !err_clr);
      if (base_reg_ld) m_base = base_reg_data;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] o;
    bit t, psh, pp, oe, ue;
    if ($time > 1) begin
      model_comb(o, t, psh, pp, oe, ue);
      chk("m_out_addr", 32'(out_addr), 32'(o));
      chk("m_jmp_taken", 32'(jmp_taken), 32'(t));
      chk("m_sp", 32'(sp), 32'(m_stk.size()));
      chk("m_full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
      chk("m_empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      chk("m_ovf", 32'(ovf_err), 32'(m_ovf));
      chk("m_unf", 32'(unf_err), 32'(m_unf));
    end
  end

  task automatic drive(input bit en, input logic [2:0] m, input logic [7:0] pc,
                       input logic [7:0] off);
    jmp_en = en; jmp_mode = m; pc_in = pc; base_reg_offset = off;
    base_reg_ld = 0; base_reg_data = '0; lr_addr = '0; err_clr = 0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    drive(0, 3'd0, 8'h00, 8'h00);
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(stack_empty), 1);
    chk("rst_full", 32'(stack_full), 0);

    // Base/relative/absolute targets
    drive(0, 3'd0, 8'h00, 8'h00);
    base_reg_ld = 1; base_reg_data = 8'h0A;
    tick();
    drive(1, 3'd1, 8'h00, 8'hA7);
    chk("base_out", 32'(out_addr), 32'h00B1);
    chk("base_taken", 32'(jmp_taken), 1);
    tick();
    drive(1, 3'd2, 8'h10, 8'hFE);
    chk("rel_out", 32'(out_addr), 32'h000E);
    tick();
    drive(1, 3'd0, 8'h00, 8'h12);
    chk("abs_out", 32'(out_addr), 32'h0012);
    tick();
    drive(1, 3'd6, 8'h44, 8'h12);
    chk("rsvd_out", 32'(out_addr), 32'h0045);
    chk("rsvd_taken", 32'(jmp_taken), 0);
    tick();

    // Nested calls and returns
    drive(1, 3'd4, 8'h20, 8'h00); tick(); chk("call1_sp", 32'(sp), 1);
    drive(1, 3'd4, 8'h40, 8'h00); tick(); chk("call2_sp", 32'(sp), 2);
    drive(1, 3'd4, 8'h60, 8'h00); tick(); chk("call3_sp", 32'(sp), 3);
    drive(1, 3'd5, 8'h00, 8'h00); chk("ret1", 32'(out_addr), 32'h61); tick();
    drive(1, 3'd5, 8'h00, 8'h00); chk("ret2", 32'(out_addr), 32'h41); tick();
    drive(1, 3'd5, 8'h00, 8'h00); chk("ret3", 32'(out_addr), 32'h21); tick();
    chk("nest_sp", 32'(sp), 0);
    chk("nest_empty", 32'(stack_empty), 1);

    // Overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd4, 8'(8'h80 + i), 8'h00);
      tick();
    end
    chk("ovf_full", 32'(stack_full), 1);
    drive(1, 3'd4, 8'h90, 8'h05);
    chk("ovf_taken", 32'(jmp_taken), 1);
    chk("ovf_target", 32'(out_addr), 32'h0F);
    tick();
    chk("ovf_sp", 32'(sp), 4);
    chk("ovf_flag", 32'(ovf_err), 1);
    drive(0, 3'd0, 8'h00, 8'h00);
    err_clr = 1;
    tick();
    chk("ovf_clr", 32'(ovf_err), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd5, 8'h00, 8'h00);
      chk("ovf_drain", 32'(out_addr), 32'(8'h84 - i));
      tick();
    end

    // Underflow; clear coinciding with a new error keeps the flag
    drive(1, 3'd5, 8'h33, 8'h00);
    chk("unf_out", 32'(out_addr), 32'h34);
    chk("unf_taken", 32'(jmp_taken), 0);
    tick();
    chk("unf_flag", 32'(unf_err), 1);
    drive(1, 3'd5, 8'h33, 8'h00);
    err_clr = 1;
    tick();
    chk("unf_clr_race", 32'(unf_err), 1);

    // Same-cycle base load with CALL uses the old base
    drive(1, 3'd4, 8'h70, 8'h01);
    base_reg_ld = 1; base_reg_data = 8'h50;
    #1 chk("ld_call_out", 32'(out_addr), 32'h0B);
    tick();
    drive(1, 3'd1, 8'h00, 8'h01);
    chk("ld_base_out", 32'(out_addr), 32'h51);
    tick();
    drive(1, 3'd3, 8'h00, 8'h00);
    lr_addr = 8'h69;
    #1 chk("lr_out", 32'(out_addr), 32'h69);
    tick();

    // Reset mid-operation discards pending push
    drive(1, 3'd4, 8'h72, 8'h00);
    tick();
    chk("pre_rst_sp", 32'(sp), 2);
    drive(1, 3'd4, 8'h74, 8'h00);
    #1 rst = 1;
    #1;
    chk("mid_rst_sp", 32'(sp), 0);
    chk("mid_rst_unf", 32'(unf_err), 0);
    chk("mid_rst_ovf", 32'(ovf_err), 0);
    chk("mid_rst_empty", 32'(stack_empty), 1);
    rst = 0;
    drive(1, 3'd5, 8'h10, 8'h00);
    chk("post_rst_ret_taken", 32'(jmp_taken), 0);
    tick();
    chk("post_rst_unf", 32'(unf_err), 1);
    chk("post_rst_sp", 32'(sp), 0);
    drive(0, 3'd0, 8'h00, 8'h00);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
